axi_read_arbiter: RTL and testbench

Shares the CPU core's single AXI master read channel (AR/R) between two requesters: port 0, instruction fetch page loads, and port 1, data-memory loads.
- Grants one burst at a time, with round-robin on contention.
- Forwards the granted requester's AR request to the bus.
- Routes R beats back to that requester only.
- Sits between the fetch/load units and the core's M_AXI interface; the AW/W/B channels are not handled here.

---
 rtl/axi_arb_pkg.sv | 14 +
 rtl/axi_read_arbiter_if.sv | 26 ++
 rtl/axi_read_arbiter_rr_arbiter_2.sv | 23 ++
 rtl/axi_read_arbiter.sv | 120 ++++++++++++
 tb/tb_axi_read_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// State encodings and requester indices shared by the
// two-port AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b11
    } arb_state_t;

    localparam logic REQ_IFETCH = 1'b0;
    localparam logic REQ_DLOAD  = 1'b1;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel (AR/R) signal bundle; master drives AR,
// slave drives R.
interface axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_read_arbiter_rr_arbiter_2.sv
// Two-way round-robin pick: on contention the port that
// did not win last time gets the grant.
module rr_arbiter_2
    import axi_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_valid
);

    always_comb begin
        grant = REQ_IFETCH;
        unique case (1'b1)
            valid == 2'b11: grant = ~last_grant;
            valid == 2'b10: grant = REQ_DLOAD;
            default:        grant = REQ_IFETCH;
        endcase
    end

    assign any_valid = |valid;

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master between instruction fetch
// (port 0) and data loads (port 1), one burst at a time.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic              ACLK,
    input  logic              ARST,
    axi_read_arbiter_if.slave  s0,
    axi_read_arbiter_if.slave  s1,
    axi_read_arbiter_if.master m_axi
);

    arb_state_t state_q, state_d;

    logic                          grant_q;
    logic                          last_grant_q;
    logic                          grant_d;
    logic                          any_valid;
    logic                          arvalid_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]                    arlen_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata;
    logic                          rready_g;

    rr_arbiter_2 u_rr (
        .valid      ({s1.ARVALID, s0.ARVALID}),
        .last_grant (last_grant_q),
        .grant      (grant_d),
        .any_valid  (any_valid)
    );

    assign m_axi.ARADDR  = araddr_q;
    assign m_axi.ARLEN   = arlen_q;
    assign m_axi.ARVALID = arvalid_q;

    assign rdata     = m_axi.RDATA;
    assign s0.RDATA  = rdata;
    assign s1.RDATA  = rdata;
    assign s0.RRESP  = m_axi.RRESP;
    assign s1.RRESP  = m_axi.RRESP;
    assign s0.RLAST  = m_axi.RLAST;
    assign s1.RLAST  = m_axi.RLAST;

    assign rready_g = (grant_q == REQ_DLOAD) ? s1.RREADY
                                             : s0.RREADY;

    always_comb begin
        state_d      = state_q;
        s0.ARREADY   = 1'b0;
        s1.ARREADY   = 1'b0;
        s0.RVALID    = 1'b0;
        s1.RVALID    = 1'b0;
        m_axi.RREADY = 1'b0;
        // Reset behaves like idle: drain stale beats, grant nothing.
        if (ARST) begin
            state_d      = S_IDLE;
            m_axi.RREADY = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    m_axi.RREADY = 1'b1;
                    if (any_valid) begin
                        s0.ARREADY = (grant_d == REQ_IFETCH);
                        s1.ARREADY = (grant_d == REQ_DLOAD);
                        state_d    = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_axi.ARREADY) state_d = S_DATA;
                end
                S_DATA: begin
                    s0.RVALID    = m_axi.RVALID &&
                                   (grant_q == REQ_IFETCH);
                    s1.RVALID    = m_axi.RVALID &&
                                   (grant_q == REQ_DLOAD);
                    m_axi.RREADY = rready_g;
                    if (m_axi.RVALID && rready_g && m_axi.RLAST)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            grant_q      <= REQ_IFETCH;
            last_grant_q <= REQ_DLOAD;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_q   <= grant_d;
                        arvalid_q <= 1'b1;
                        araddr_q  <= grant_d ? s1.ARADDR
                                             : s0.ARADDR;
                        arlen_q   <= grant_d ? s1.ARLEN
                                             : s0.ARLEN;
                    end
                end
                S_ADDR: begin
                    if (m_axi.ARREADY) arvalid_q <= 1'b0;
                end
                S_DATA: begin
                    if (state_d == S_IDLE) last_grant_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with a simple AXI slave
// model and auto-repeating requesters.
module tb_axi_read_arbiter;

    logic ACLK = 1'b0;
    logic ARST = 1'b1;
    always #5 ACLK = ~ACLK;

    axi_read_arbiter_if #(32, 32) s0_if ();
    axi_read_arbiter_if #(32, 32) s1_if ();
    axi_read_arbiter_if #(32, 32) m_if ();

    axi_read_arbiter #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32)
    ) dut (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .s0    (s0_if),
        .s1    (s1_if),
        .m_axi (m_if)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int ar_delay = 0;
    int err_idx = -1;
    int b_state = 0;
    int b_len = 0;
    int b_beat = 0;
    int b_wait = 0;
    int n_len = 0;
    logic [31:0] b_addr = '0;
    logic [31:0] n_addr = '0;
    bit ar_hs = 0;
    bit r_hs = 0;

    int req_left [2];
    logic [31:0] req_addr [2];
    bit acc [2];
    bit pat_en = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int gnt_port [$];
    int gnt_cyc [$];
    int rlast_cyc [$];
    logic [31:0] ar_log [$];
    logic [34:0] rx0 [$];
    logic [34:0] rx1 [$];
    int rv0_cnt = 0;
    int rv1_cnt = 0;
    int bp_err = 0;
    int hs_total = 0;

    // Slave model, requester repeat logic and monitor. Drives at the
    // falling edge, then predicts the handshakes of the next rising edge.
    initial begin
        m_if.ARREADY = 0; m_if.RVALID = 0;
        m_if.RDATA = '0; m_if.RRESP = '0; m_if.RLAST = 0;
        s0_if.ARVALID = 0; s0_if.ARADDR = '0; s0_if.ARLEN = '0;
        s1_if.ARVALID = 0; s1_if.ARADDR = '0; s1_if.ARLEN = '0;
        s0_if.RREADY = 1; s1_if.RREADY = 1;
        req_left[0] = 0; req_left[1] = 0;
        acc[0] = 0; acc[1] = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ar_hs) begin
                b_state = 1; b_addr = n_addr;
                b_len = n_len; b_beat = 0;
            end
            if (r_hs) begin
                if (b_beat == b_len) b_state = 0;
                else b_beat++;
            end
            m_if.ARREADY = 0;
            if (!m_if.ARVALID) b_wait = 0;
            else if (b_state == 0) begin
                if (b_wait >= ar_delay) m_if.ARREADY = 1;
                else b_wait++;
            end
            m_if.RVALID = (b_state == 1);
            m_if.RDATA  = b_addr + 32'(b_beat);
            m_if.RRESP  = (b_state == 1 && b_beat == err_idx)
                          ? 2'b10 : 2'b00;
            m_if.RLAST  = (b_state == 1 && b_beat == b_len);

            if (ARST) begin
                req_left[0] = 0; s0_if.ARVALID = 0;
            end else if (acc[0]) begin
                req_left[0]--; req_addr[0] += 32'h100;
                s0_if.ARADDR = req_addr[0];
                s0_if.ARVALID = (req_left[0] > 0);
            end
            if (ARST) begin
                req_left[1] = 0; s1_if.ARVALID = 0;
            end else if (acc[1]) begin
                req_left[1]--; req_addr[1] += 32'h100;
                s1_if.ARADDR = req_addr[1];
                s1_if.ARVALID = (req_left[1] > 0);
            end
            s1_if.RREADY = pat_en ? pat[cyc % 4] : 1'b1;

            #1;
            ar_hs = m_if.ARVALID && m_if.ARREADY;
            if (ar_hs) begin
                n_addr = m_if.ARADDR; n_len = int'(m_if.ARLEN);
                ar_log.push_back(m_if.ARADDR);
                b_wait = 0;
            end
            r_hs = m_if.RVALID && m_if.RREADY;
            if (r_hs) hs_total++;
            if (r_hs && m_if.RLAST) rlast_cyc.push_back(cyc);
            acc[0] = s0_if.ARVALID && s0_if.ARREADY;
            acc[1] = s1_if.ARVALID && s1_if.ARREADY;
            if (acc[0]) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
            if (acc[1]) begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
            if (s0_if.RVALID) rv0_cnt++;
            if (s1_if.RVALID) rv1_cnt++;
            if (s0_if.RVALID && s0_if.RREADY)
                rx0.push_back({s0_if.RLAST, s0_if.RRESP, s0_if.RDATA});
            if (s1_if.RVALID && s1_if.RREADY)
                rx1.push_back({s1_if.RLAST, s1_if.RRESP, s1_if.RDATA});
            if (pat_en && m_if.RVALID && (m_if.RREADY !== s1_if.RREADY))
                bp_err++;
        end
    end

    task automatic clear_logs();
        gnt_port.delete(); gnt_cyc.delete(); rlast_cyc.delete();
        ar_log.delete(); rx0.delete(); rx1.delete();
        rv0_cnt = 0; rv1_cnt = 0; bp_err = 0; hs_total = 0;
    endtask

    task automatic request(input int p, input logic [31:0] a,
                           input logic [7:0] l, input int n);
        req_left[p] = n; req_addr[p] = a;
        if (p == 0) begin
            s0_if.ARADDR = a; s0_if.ARLEN = l; s0_if.ARVALID = 1;
        end else begin
            s1_if.ARADDR = a; s1_if.ARLEN = l; s1_if.ARVALID = 1;
        end
    endtask

    task automatic wait_rlast(input int n, input string tag);
        for (int i = 0; i < 600 && rlast_cyc.size() < n; i++)
            @(negedge ACLK);
        #2;
        tests++;
        if (rlast_cyc.size() < n) begin
            fails++;
            $display("FAIL %s_timeout: rlast seen %0d, required %0d",
                     tag, rlast_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        ARST = 1;
        repeat (3) @(negedge ACLK);
        #2;
        tests++;
        if (m_if.ARVALID !== 1'b0) begin fails++;
            $display("FAIL rst_arvalid: got %b want 0", m_if.ARVALID); end
        tests++;
        if (m_if.ARADDR !== 32'h0) begin fails++;
            $display("FAIL rst_araddr: got %h want 0", m_if.ARADDR); end
        tests++;
        if (m_if.ARLEN !== 8'h0) begin fails++;
            $display("FAIL rst_arlen: got %h want 0", m_if.ARLEN); end
        tests++;
        if ({s0_if.ARREADY, s1_if.ARREADY} !== 2'b00) begin fails++;
            $display("FAIL rst_arready: got %b%b want 00",
                     s0_if.ARREADY, s1_if.ARREADY); end
        tests++;
        if ({s0_if.RVALID, s1_if.RVALID} !== 2'b00) begin fails++;
            $display("FAIL rst_rvalid: got %b%b want 00",
                     s0_if.RVALID, s1_if.RVALID); end
        tests++;
        if (m_if.RREADY !== 1'b1) begin fails++;
            $display("FAIL rst_rready: got %b want 1", m_if.RREADY); end
        @(negedge ACLK);
        ARST = 0;
    endtask

    task automatic test_single();
        int t_acc = -1, n_acc = 0, arv_first = -1, n_arv = 0;
        int bad = 0, bad_d = 0;
        ar_delay = 3;
        @(negedge ACLK);
        clear_logs();
        request(0, 32'h2000_0000, 8'h1f, 1);
        for (int i = 0; i < 300; i++) begin
            #2;
            if (s0_if.ARREADY) begin n_acc++; t_acc = cyc; end
            if (m_if.ARVALID) begin
                if (arv_first < 0) arv_first = cyc;
                n_arv++;
                if (m_if.ARADDR !== 32'h2000_0000 ||
                    m_if.ARLEN !== 8'h1f) bad++;
            end
            if (rlast_cyc.size() > 0) break;
            @(negedge ACLK);
        end
        tests++;
        if (n_acc != 1) begin fails++;
            $display("FAIL single_arready_pulses: got %0d want 1", n_acc); end
        tests++;
        if (arv_first != t_acc + 1) begin fails++;
            $display("FAIL single_arvalid_lat: got %0d want %0d",
                     arv_first, t_acc + 1); end
        tests++;
        if (n_arv != 4 || bad != 0) begin fails++;
            $display("FAIL single_arvalid_hold: cycles %0d bad %0d want 4/0",
                     n_arv, bad); end
        tests++;
        if (rx0.size() != 32) begin fails++;
            $display("FAIL single_beats: got %0d want 32", rx0.size()); end
        foreach (rx0[i])
            if (rx0[i] !== {i == 31, 2'b00, 32'(32'h2000_0000 + i)}) bad_d++;
        tests++;
        if (bad_d != 0) begin fails++;
            $display("FAIL single_data: bad beats %0d want 0", bad_d); end
        tests++;
        if (rv1_cnt != 0 || rx1.size() != 0) begin fails++;
            $display("FAIL single_s1_quiet: rvalid %0d want 0", rv1_cnt); end
        ar_delay = 0;
        @(negedge ACLK);
    endtask

    task automatic test_simultaneous();
        @(negedge ACLK); ARST = 1;
        repeat (2) @(negedge ACLK);
        ARST = 0;
        @(negedge ACLK);
        clear_logs();
        request(0, 32'h1000, 8'd3, 1);
        request(1, 32'h8000, 8'd3, 1);
        wait_rlast(2, "simul");
        tests++;
        if (gnt_port.size() != 2 || gnt_port[0] != 0 || gnt_port[1] != 1)
        begin fails++;
            $display("FAIL simul_order: n %0d first %0d want 2 grants 0,1",
                     gnt_port.size(), gnt_port.size() ? gnt_port[0] : -1);
        end
        tests++;
        if (gnt_cyc.size() < 2 || rlast_cyc.size() < 1 ||
            gnt_cyc[1] != rlast_cyc[0] + 1) begin fails++;
            $display("FAIL simul_regrant_cycle: got %0d want %0d",
                     gnt_cyc.size() > 1 ? gnt_cyc[1] : -1,
                     rlast_cyc.size() ? rlast_cyc[0] + 1 : -1);
        end
        tests++;
        if (ar_log.size() != 2 || ar_log[0] !== 32'h1000 ||
            ar_log[1] !== 32'h8000) begin fails++;
            $display("FAIL simul_araddr: got %h want 00008000",
                     ar_log.size() > 1 ? ar_log[1] : 32'hx);
        end
        tests++;
        if (rx0.size() != 4 || rx1.size() != 4) begin fails++;
            $display("FAIL simul_beats: got %0d/%0d want 4/4",
                     rx0.size(), rx1.size());
        end
        @(negedge ACLK);
    endtask

    task automatic test_round_robin();
        int exp_p [4] = '{0, 1, 0, 1};
        logic [31:0] exp_a [4];
        int bad = 0;
        exp_a = '{32'h4000, 32'h5000, 32'h4100, 32'h5100};
        @(negedge ACLK);
        clear_logs();
        request(0, 32'h4000, 8'd1, 2);
        request(1, 32'h5000, 8'd1, 2);
        wait_rlast(4, "rr");
        for (int i = 0; i < 4; i++)
            if (i >= gnt_port.size() || gnt_port[i] != exp_p[i] ||
                i >= ar_log.size() || ar_log[i] !== exp_a[i]) bad++;
        tests++;
        if (bad != 0 || gnt_port.size() != 4) begin fails++;
            $display("FAIL rr_order: bad %0d grants %0d want 0 and 4",
                     bad, gnt_port.size()); end
        tests++;
        if (rx0.size() != 4 || rx1.size() != 4) begin fails++;
            $display("FAIL rr_beats: got %0d/%0d want 4/4",
                     rx0.size(), rx1.size()); end
        @(negedge ACLK);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        @(negedge ACLK);
        clear_logs();
        pat_en = 1;
        request(1, 32'h3000, 8'd7, 1);
        wait_rlast(1, "bp");
        tests++;
        if (bp_err != 0) begin fails++;
            $display("FAIL bp_rready_mirror: mismatches %0d want 0", bp_err); end
        tests++;
        if (rx1.size() != 8) begin fails++;
            $display("FAIL bp_beats: got %0d want 8", rx1.size()); end
        foreach (rx1[i])
            if (rx1[i] !== {i == 7, 2'b00, 32'(32'h3000 + i)}) bad++;
        tests++;
        if (bad != 0) begin fails++;
            $display("FAIL bp_data: bad beats %0d want 0", bad); end
        tests++;
        if (rv0_cnt != 0) begin fails++;
            $display("FAIL bp_s0_quiet: rvalid %0d want 0", rv0_cnt); end
        pat_en = 0;
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid();
        int bad = 0, bad_d = 0, i;
        @(negedge ACLK);
        clear_logs();
        request(0, 32'h6000, 8'd31, 1);
        #2;
        for (i = 0; i < 200 && rx0.size() < 10; i++) begin
            @(negedge ACLK); #2;
        end
        @(negedge ACLK);
        ARST = 1;
        repeat (3) begin
            @(negedge ACLK); #2;
            if (m_if.ARVALID !== 1'b0 || m_if.ARADDR !== 32'h0 ||
                m_if.ARLEN !== 8'h0 || m_if.RREADY !== 1'b1 ||
                s0_if.RVALID !== 1'b0 || s1_if.RVALID !== 1'b0 ||
                s0_if.ARREADY !== 1'b0 || s1_if.ARREADY !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++;
            $display("FAIL mid_reset_values: bad cycles %0d want 0", bad); end
        @(negedge ACLK);
        ARST = 0;
        for (i = 0; i < 100 && (b_state != 0 || r_hs); i++) begin
            @(negedge ACLK); #2;
            if (s0_if.RVALID || s1_if.RVALID || m_if.RREADY !== 1'b1)
                bad_d++;
        end
        tests++;
        if (bad_d != 0) begin fails++;
            $display("FAIL mid_drain: bad cycles %0d want 0", bad_d); end
        tests++;
        if (hs_total != 32 || rx0.size() != 10) begin fails++;
            $display("FAIL mid_beats: bus %0d s0 %0d want 32/10",
                     hs_total, rx0.size()); end
        @(negedge ACLK);
        clear_logs();
        request(0, 32'h7000, 8'd3, 1);
        wait_rlast(1, "mid_after");
        tests++;
        if (rx0.size() != 4 || rx0[0] !== {1'b0, 2'b00, 32'h7000} ||
            rx0[3] !== {1'b1, 2'b00, 32'h7003}) begin fails++;
            $display("FAIL mid_after_data: beats %0d want 4", rx0.size()); end
        @(negedge ACLK);
    endtask

    task automatic test_error();
        int bad = 0;
        @(negedge ACLK);
        clear_logs();
        err_idx = 4;
        request(0, 32'h9000, 8'd7, 1);
        wait_rlast(1, "err");
        tests++;
        if (rx0.size() != 8) begin fails++;
            $display("FAIL err_beats: got %0d want 8", rx0.size()); end
        foreach (rx0[i])
            if (rx0[i][33:32] !== ((i == 4) ? 2'b10 : 2'b00)) bad++;
        tests++;
        if (bad != 0) begin fails++;
            $display("FAIL err_rresp: bad beats %0d want 0", bad); end
        err_idx = -1;
        @(negedge ACLK);
        request(1, 32'hA000, 8'd0, 1);
        wait_rlast(2, "err_next");
        tests++;
        if (rx1.size() != 1 || rx1[0] !== {1'b1, 2'b00, 32'hA000}) begin
            fails++;
            $display("FAIL err_next_burst: beats %0d want 1", rx1.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
